hazard_unit_id: RTL and testbench
=================================

Name: hazard_unit_ID

Overview:
- Decode-stage hazard and pipeline-control unit. It is the producer side of the EX-stage operand-forwarding path.
- Compares ID-stage source registers against in-flight destinations in EXE and MEM, and decides when forwarding cannot cover a dependence.
- Drives freeze, bubble and flush controls for the IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Tracks data-memory wait states and a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, width of stall and wait counters.
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before the error flag sets.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- forward_en  in  1  1 = EX forwarding active; 0 = no forwarding, full RAW interlock.
- src1_ID  in  REG_AW  first source of the instruction in ID.
- src2_ID  in  REG_AW  second source of the instruction in ID.
- two_src_ID  in  1  ID instruction reads src2.
- dest_EXE  in  REG_AW  destination of the instruction in EXE.
- WB_EN_EXE  in  1  EXE instruction writes back.
- MEM_R_EN_EXE  in  1  EXE instruction is a load.
- dest_MEM  in  REG_AW  destination of the instruction in MEM.
- WB_EN_MEM  in  1  MEM instruction writes back.
- MEM_ACC_MEM  in  1  MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken_EXE  in  1  taken branch resolved in EXE.
- freeze_IF  out  1  hold PC and IF/ID.
- bubble_EXE  out  1  load a NOP into ID/EXE.
- flush_IF_ID  out  1  clear IF/ID.
- freeze_all  out  1  hold every pipeline register.
- mem_timeout_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of data-hazard stall cycles.
- wait_cnt  out  CNT_W  current consecutive memory-wait length.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = RUN.
  - stall_cnt = 0, wait_cnt = 0, mem_timeout_err = 0.
  - All control outputs are 0 while reset is held.
- Register 0 is an ordinary register and is compared like any other.
- Match terms (combinational):
  - m1x = WB_EN_EXE && src1_ID == dest_EXE.
  - m2x = two_src_ID && WB_EN_EXE && src2_ID == dest_EXE.
  - m1m and m2m are the same, using dest_MEM and WB_EN_MEM.
- Data hazard (raw_hz):
  - forward_en = 1: (m1x || m2x) && MEM_R_EN_EXE. Load-use only; all other dependences are forwarded.
  - forward_en = 0: m1x || m2x || m1m || m2m.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when MEM_ACC_MEM && !mem_ready.
  - MEM_WAIT -> RUN on the first cycle with mem_ready = 1.
  - freeze_all is Mealy: MEM_ACC_MEM && !mem_ready in either state, so the first wait cycle freezes with zero latency.
- Output priority, highest first:
  1. freeze_all = 1: freeze_IF = 1, bubble_EXE = 0, flush_IF_ID = 0. Branch and hazard actions are deferred because the EXE/ID contents are held and re-presented.
  2. branch_taken_EXE: flush_IF_ID = 1, bubble_EXE = 1, freeze_IF = 0. The ID instruction is on the wrong path, so raw_hz is ignored that cycle.
  3. raw_hz: freeze_IF = 1, bubble_EXE = 1.
  4. Otherwise all controls are 0.
- Latency: all control outputs are combinational, same cycle as the inputs. Counters update on the rising edge.
- stall_cnt:
  - Increments on every edge where case 3 is active.
  - Saturates at all-ones, no wrap.
- wait_cnt:
  - Increments on each edge with freeze_all = 1 and saturates.
  - Clears on an edge with freeze_all = 0.
- mem_timeout_err:
  - Sets on the edge where wait_cnt would reach MEM_TIMEOUT.
  - Cleared only by reset.
  - Does not alter pipeline control.
- Reset asserted mid-wait or mid-stall: state and counters clear immediately. No pending flush or stall survives reset.

Decomposition:
- Shared pipeline package holds:
  - REG_AW.
  - The state enum RUN/MEM_WAIT.
  - A hazard-match function (src, dest, wb_en, used), reused by the EX forwarding logic.
- One natural sub-module: sat_counter, a parameterised width saturating incrementer with synchronous clear, instantiated twice.

Test Plan:
- Load-use hazard:
  - Stimulus: forward_en = 1, MEM_R_EN_EXE = 1, WB_EN_EXE = 1, dest_EXE = 3, src1_ID = 3.
  - Response: freeze_IF = 1 and bubble_EXE = 1 for that cycle; stall_cnt 0 -> 1.
  - Repeat with MEM_R_EN_EXE = 0: all controls 0.
- Second source unused:
  - Stimulus: src2_ID = 7, two_src_ID = 0, WB_EN_MEM = 1, dest_MEM = 7, forward_en = 0.
  - Response: no stall.
  - Set two_src_ID = 1: freeze_IF = 1, bubble_EXE = 1.
- Branch during hazard:
  - Stimulus: raw_hz condition true and branch_taken_EXE = 1.
  - Response: flush_IF_ID = 1, bubble_EXE = 1, freeze_IF = 0; stall_cnt unchanged.
- Memory wait:
  - Stimulus: MEM_ACC_MEM = 1, mem_ready = 0 for 4 cycles, then 1, with branch_taken_EXE = 1 throughout.
  - Response: freeze_all = 1 for 4 cycles with wait_cnt 1..4 and no flush. The 5th cycle has freeze_all = 0 and flush_IF_ID = 1, and wait_cnt clears to 0.
- Timeout:
  - Stimulus: MEM_TIMEOUT = 4, mem_ready held 0 for 6 cycles.
  - Response: mem_timeout_err rises on the 4th edge and stays 1 after mem_ready returns, until rst_n = 0.
- Asynchronous reset mid-wait:
  - Stimulus: drop rst_n between clock edges during MEM_WAIT.
  - Response: wait_cnt, stall_cnt and mem_timeout_err are 0 and all controls 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_unit_id_pkg.sv
// Shared pipeline definitions for the decode-stage hazard unit.
//   REG_AW     : register-index width
//   hz_state_e : memory-wait FSM states (RUN / MEM_WAIT)
//   hz_match() : "does this source depend on that in-flight destination"
//                test, also used by the EX forwarding muxes
package hazard_unit_id_pkg;

    localparam int REG_AW = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Register 0 is not special: it matches like any other index.
    function automatic logic hz_match(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dest,
                                      input logic              wb_en,
                                      input logic              used);
        return used && wb_en && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_unit_id_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear to zero on the next edge (wins over inc_i)
//   inc_i      : increment on the next edge, sticks at all-ones
//   cnt_o      : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit_id.sv
// Decode-stage hazard and pipeline-control unit.
// Detects RAW dependences of the ID instruction on EXE/MEM destinations,
// decides when forwarding cannot cover them, and drives freeze / bubble /
// flush for IF/ID, ID/EXE and EXE/MEM. Also tracks data-memory waits.
//   Inputs : forward_en, src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE,
//            MEM_R_EN_EXE, dest_MEM, WB_EN_MEM, MEM_ACC_MEM, mem_ready,
//            branch_taken_EXE
//   Outputs: freeze_IF, bubble_EXE, flush_IF_ID, freeze_all (combinational),
//            mem_timeout_err (sticky), stall_cnt, wait_cnt (registered)
module hazard_unit_id
    import hazard_unit_id_pkg::*;
#(
    parameter int REG_AW      = hazard_unit_id_pkg::REG_AW,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              forward_en,
    input  logic [REG_AW-1:0] src1_ID,
    input  logic [REG_AW-1:0] src2_ID,
    input  logic              two_src_ID,
    input  logic [REG_AW-1:0] dest_EXE,
    input  logic              WB_EN_EXE,
    input  logic              MEM_R_EN_EXE,
    input  logic [REG_AW-1:0] dest_MEM,
    input  logic              WB_EN_MEM,
    input  logic              MEM_ACC_MEM,
    input  logic              mem_ready,
    input  logic              branch_taken_EXE,
    output logic              freeze_IF,
    output logic              bubble_EXE,
    output logic              flush_IF_ID,
    output logic              freeze_all,
    output logic              mem_timeout_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  wait_cnt
);

    hz_state_e state_q, state_d;
    logic      m1x, m2x, m1m, m2m, raw_hz;
    logic      mem_busy, stall_inc;
    logic      err_q, err_d;

    assign m1x = hz_match(src1_ID, dest_EXE, WB_EN_EXE, 1'b1);
    assign m2x = hz_match(src2_ID, dest_EXE, WB_EN_EXE, two_src_ID);
    assign m1m = hz_match(src1_ID, dest_MEM, WB_EN_MEM, 1'b1);
    assign m2m = hz_match(src2_ID, dest_MEM, WB_EN_MEM, two_src_ID);

    // With forwarding only a load in EXE cannot be bypassed in time;
    // without it every in-flight producer must drain first.
    assign raw_hz = forward_en ? ((m1x || m2x) && MEM_R_EN_EXE)
                               : (m1x || m2x || m1m || m2m);

    // Mealy: the very first wait cycle already freezes the pipe.
    assign mem_busy = MEM_ACC_MEM && !mem_ready;

    always_comb begin
        state_d     = state_q;
        freeze_IF   = 1'b0;
        bubble_EXE  = 1'b0;
        flush_IF_ID = 1'b0;
        freeze_all  = 1'b0;
        stall_inc   = 1'b0;

        case (state_q)
            RUN:      if (mem_busy)  state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready) state_d = RUN;
            default:                 state_d = RUN;
        endcase

        // Controls are forced low while reset is held.
        if (rst_n) begin
            if (mem_busy) begin
                // EXE/ID contents are held and re-presented, so a pending
                // branch or hazard is acted on once the wait ends.
                freeze_all = 1'b1;
                freeze_IF  = 1'b1;
            end else if (branch_taken_EXE) begin
                // ID holds a wrong-path instruction; its hazard is moot.
                flush_IF_ID = 1'b1;
                bubble_EXE  = 1'b1;
            end else if (raw_hz) begin
                freeze_IF  = 1'b1;
                bubble_EXE = 1'b1;
                stall_inc  = 1'b1;
            end
        end
    end

    // Set on the edge that takes wait_cnt to MEM_TIMEOUT; sticky until reset.
    assign err_d = err_q || (freeze_all && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!freeze_all),
        .inc_i (freeze_all),
        .cnt_o (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_unit_id.sv
// Bench for hazard_unit_id: directed scenarios then randomized traffic,
// all checked against a behavioural model of the control rules.
module tb_hazard_unit_id;

    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int TMO  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          forward_en, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE;
    logic          WB_EN_MEM, MEM_ACC_MEM, mem_ready, branch_taken_EXE;
    logic [AW-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
    logic          freeze_IF, bubble_EXE, flush_IF_ID, freeze_all, mem_timeout_err;
    logic [CW-1:0] stall_cnt, wait_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int m_stall = 0;
    int m_wait  = 0;
    bit m_err   = 0;

    always #5 clk = ~clk;

    hazard_unit_id #(.REG_AW(AW), .CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
        .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .MEM_ACC_MEM(MEM_ACC_MEM),
        .mem_ready(mem_ready), .branch_taken_EXE(branch_taken_EXE),
        .freeze_IF(freeze_IF), .bubble_EXE(bubble_EXE), .flush_IF_ID(flush_IF_ID),
        .freeze_all(freeze_all), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .wait_cnt(wait_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Expected {freeze_IF, bubble_EXE, flush_IF_ID, freeze_all}.
    function automatic logic [3:0] exp_ctrl();
        bit hx, hm, need, busy;
        if (!rst_n) return 4'b0000;
        hx   = WB_EN_EXE && (src1_ID == dest_EXE || (two_src_ID && src2_ID == dest_EXE));
        hm   = WB_EN_MEM && (src1_ID == dest_MEM || (two_src_ID && src2_ID == dest_MEM));
        need = forward_en ? (hx && MEM_R_EN_EXE) : (hx || hm);
        busy = MEM_ACC_MEM && !mem_ready;
        if (busy)             return 4'b1001;
        if (branch_taken_EXE) return 4'b0110;
        if (need)             return 4'b1100;
        return 4'b0000;
    endfunction

    task automatic chk_ctrl(input logic [3:0] e);
        chk("freeze_IF",   32'(freeze_IF),   32'(e[3]));
        chk("bubble_EXE",  32'(bubble_EXE),  32'(e[2]));
        chk("flush_IF_ID", 32'(flush_IF_ID), 32'(e[1]));
        chk("freeze_all",  32'(freeze_all),  32'(e[0]));
    endtask

    task automatic chk_cnt();
        chk("stall_cnt", 32'(stall_cnt),       32'(m_stall));
        chk("wait_cnt",  32'(wait_cnt),        32'(m_wait));
        chk("tmo_err",   32'(mem_timeout_err), 32'(m_err));
    endtask

    // Entered and left at posedge+1; inputs already applied.
    task automatic cyc();
        logic [3:0] e;
        #2;
        e = exp_ctrl();
        chk_ctrl(e);
        @(posedge clk);
        if (rst_n) begin
            if (e == 4'b1100) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (e[0]) begin
                m_wait = (m_wait < CMAX) ? m_wait + 1 : CMAX;
                if (m_wait >= TMO) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
        #1;
        chk_cnt();
    endtask

    // Asynchronous reset dropped between edges; effect must be immediate.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        m_stall = 0; m_wait = 0; m_err = 0;
        chk_ctrl(4'b0000);
        chk_cnt();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle();
        forward_en = 1; two_src_ID = 0; WB_EN_EXE = 0; MEM_R_EN_EXE = 0;
        WB_EN_MEM = 0; MEM_ACC_MEM = 0; mem_ready = 1; branch_taken_EXE = 0;
        src1_ID = 1; src2_ID = 2; dest_EXE = 9; dest_MEM = 10;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // Hazard present while reset held: controls must stay low.
        WB_EN_EXE = 1; MEM_R_EN_EXE = 1; dest_EXE = 3; src1_ID = 3;
        #3;
        chk_ctrl(4'b0000);
        chk_cnt();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load-use.
        cyc();
        MEM_R_EN_EXE = 0;
        cyc();

        // Second source only counts when used.
        idle();
        forward_en = 0; WB_EN_MEM = 1; dest_MEM = 7; src2_ID = 7; src1_ID = 1;
        cyc();
        two_src_ID = 1;
        cyc();

        // Branch overrides a hazard.
        branch_taken_EXE = 1;
        cyc();

        // Memory wait with a branch pending throughout.
        idle();
        branch_taken_EXE = 1; MEM_ACC_MEM = 1; mem_ready = 0;
        repeat (4) cyc();
        mem_ready = 1;
        cyc();

        // Reset mid-wait, with stall counter non-zero beforehand.
        idle();
        WB_EN_EXE = 1; MEM_R_EN_EXE = 1; dest_EXE = 0; src1_ID = 0;
        cyc();
        MEM_ACC_MEM = 1; mem_ready = 0;
        repeat (2) cyc();
        mid_reset();

        // Timeout: flag sets on the 4th wait edge and stays.
        idle();
        MEM_ACC_MEM = 1; mem_ready = 0;
        repeat (6) cyc();
        mem_ready = 1;
        repeat (2) cyc();
        mid_reset();

        // Randomized traffic over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            forward_en       = 1'($urandom_range(0, 1));
            two_src_ID       = 1'($urandom_range(0, 1));
            WB_EN_EXE        = 1'($urandom_range(0, 1));
            MEM_R_EN_EXE     = 1'($urandom_range(0, 1));
            WB_EN_MEM        = 1'($urandom_range(0, 1));
            MEM_ACC_MEM      = 1'($urandom_range(0, 1));
            mem_ready        = ($urandom_range(0, 2) != 0);
            branch_taken_EXE = ($urandom_range(0, 5) == 0);
            src1_ID          = AW'($urandom_range(0, 3));
            src2_ID          = AW'($urandom_range(0, 3));
            dest_EXE         = AW'($urandom_range(0, 3));
            dest_MEM         = AW'($urandom_range(0, 3));
            if (i == 200) mid_reset();
            else          cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
